// File: rtl/count_pkg.sv
// Shared widths, snapshot payload layout and level-width helper for count_snapshot.
package count_pkg;

  localparam int unsigned CNT_W       = 4;
  localparam int unsigned EPOCH_W_DEF = 8;
  localparam int unsigned DEPTH_DEF   = 4;

  // One captured sample: epoch in the upper bits, counter value in the lower bits.
  typedef struct packed {
    logic [EPOCH_W_DEF-1:0] epoch;
    logic [CNT_W-1:0]       count;
  } snap_entry_t;

  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/count_snapshot_if.sv
// Valid/ready snapshot channel from count_snapshot to its sink.
interface count_snapshot_if
  import count_pkg::*;
#(
  parameter int unsigned WIDTH   = CNT_W,
  parameter int unsigned EPOCH_W = EPOCH_W_DEF
);

  logic               snap_valid;
  logic               snap_ready;
  logic [WIDTH-1:0]   snap_count;
  logic [EPOCH_W-1:0] snap_epoch;

  modport master (
    output snap_valid,
    output snap_count,
    output snap_epoch,
    input  snap_ready
  );

  modport slave (
    input  snap_valid,
    input  snap_count,
    input  snap_epoch,
    output snap_ready
  );

endinterface

// File: rtl/snap_fifo.sv
// First-word-fall-through FIFO with a registered head word and registered status flags.
module snap_fifo
  import count_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned DATA_W = EPOCH_W_DEF + CNT_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout,
  output logic                      empty,
  output logic                      full,
  output logic [level_w(DEPTH)-1:0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = level_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [DATA_W-1:0] r_dout;
  logic              r_empty;
  logic              r_full;

  logic              w_push_ok;
  logic              w_pop_ok;
  logic [AW-1:0]     w_wr_ptr_n;
  logic [AW-1:0]     w_rd_ptr_n;
  logic [LW-1:0]     w_level_n;
  logic [DATA_W-1:0] w_dout_n;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    w_pop_ok   = pop && !r_empty;
    w_push_ok  = push && (!r_full || w_pop_ok);
    w_wr_ptr_n = r_wr_ptr + AW'(w_push_ok);
    w_rd_ptr_n = r_rd_ptr + AW'(w_pop_ok);
    w_level_n  = r_level + LW'(w_push_ok) - LW'(w_pop_ok);
    w_dout_n   = r_dout;
    if (w_level_n != '0) begin
      // The next head is the word being written right now when it lands in the read slot.
      if (w_push_ok && (w_rd_ptr_n == r_wr_ptr)) begin
        w_dout_n = din;
      end else begin
        w_dout_n = r_mem[w_rd_ptr_n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_dout   <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_n;
      r_rd_ptr <= w_rd_ptr_n;
      r_level  <= w_level_n;
      r_dout   <= w_dout_n;
      r_empty  <= (w_level_n == '0);
      r_full   <= (w_level_n == LW'(DEPTH));
    end
  end

  assign dout  = r_dout;
  assign empty = r_empty;
  assign full  = r_full;
  assign level = r_level;

endmodule

// File: rtl/count_snapshot.sv
// Tracks wraps of the upstream counter and queues {epoch, count_val} samples on each trigger.
module count_snapshot
  import count_pkg::*;
#(
  parameter int unsigned WIDTH   = CNT_W,
  parameter int unsigned EPOCH_W = EPOCH_W_DEF,
  parameter int unsigned DEPTH   = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          count_val,
  input  logic                      trig,
  input  logic                      clr_ovf,
  count_snapshot_if.master          snap,
  output logic [level_w(DEPTH)-1:0] level,
  output logic                      overflow
);

  localparam int unsigned DATA_W = EPOCH_W + WIDTH;

  logic [WIDTH-1:0]   r_prev_count;
  logic               r_prev_valid;
  logic [EPOCH_W-1:0] r_epoch;
  logic               r_overflow;

  logic               w_wrap;
  logic [EPOCH_W-1:0] w_epoch_eff;
  logic               w_pop;
  logic               w_drop;
  logic               w_empty;
  logic               w_full;
  logic [DATA_W-1:0]  w_din;
  logic [DATA_W-1:0]  w_dout;

  // Any decrease is a wrap; a same-cycle wrap is credited to the sample taken in that cycle.
  always_comb begin
    w_wrap      = r_prev_valid && (count_val < r_prev_count);
    w_epoch_eff = r_epoch + EPOCH_W'(w_wrap);
    w_pop       = !w_empty && snap.snap_ready;
    w_drop      = trig && w_full && !w_pop;
    w_din       = {w_epoch_eff, count_val};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev_count <= '0;
      r_prev_valid <= 1'b0;
      r_epoch      <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_prev_count <= count_val;
      r_prev_valid <= 1'b1;
      r_epoch      <= w_epoch_eff;
      // A new drop wins over a simultaneous clear.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  snap_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (trig),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .empty (w_empty),
    .full  (w_full),
    .level (level)
  );

  assign snap.snap_valid = !w_empty;
  assign snap.snap_count = w_dout[WIDTH-1:0];
  assign snap.snap_epoch = w_dout[DATA_W-1 -: EPOCH_W];
  assign overflow        = r_overflow;

endmodule
